// File: rtl/mul_pkg.sv
// mul_pkg: shared types for the multiplier issue stage.
// Issue FSM encoding and the operand pair bundle.
package mul_pkg;

  localparam int MUL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } issue_state_t;

  typedef struct packed {
    logic [MUL_W-1:0] a;
    logic [MUL_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mul_op_fifo.sv
// mul_op_fifo: small synchronous FIFO holding operand entries.
// Caller guarantees push only when !full and pop only when !empty.
module mul_op_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage; slots are only read after being written
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mul_issue_unit.sv
// mul_issue_unit: buffers operand pairs and issues them one at a
// time to a sequential multiplier. Optional tags: MUL_ISSUE_TAG_EN.
module mul_issue_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef MUL_ISSUE_TAG_EN
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   res_tag,
`endif
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic [WIDTH-1:0]   mul_multiplier,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_product,
  output logic               busy
);

`ifdef MUL_ISSUE_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int ENTRY_W = 2*WIDTH + (TAG_EN ? TAG_W : 0);

  issue_state_t state;
  issue_state_t state_nxt;

  logic                   push;
  logic                   pop;
  logic                   capture;
  logic                   retire;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic [ENTRY_W-1:0]     wdata;
  logic [ENTRY_W-1:0]     rdata;

`ifdef MUL_ISSUE_TAG_EN
  logic [TAG_W-1:0] op_tag;
  assign wdata = {in_tag, in_a, in_b};
`else
  assign wdata = {in_a, in_b};
`endif

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state != IDLE) || (count != '0);

  mul_op_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state plus pop/start/capture/retire strobes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    mul_start = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch on pop, result capture on done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      res_product      <= '0;
      res_valid        <= 1'b0;
`ifdef MUL_ISSUE_TAG_EN
      op_tag           <= '0;
      res_tag          <= '0;
`endif
    end else begin
      if (pop) begin
        mul_multiplicand <= rdata[2*WIDTH-1:WIDTH];
        mul_multiplier   <= rdata[WIDTH-1:0];
`ifdef MUL_ISSUE_TAG_EN
        op_tag           <= rdata[ENTRY_W-1:2*WIDTH];
`endif
      end
      if (capture) begin
        res_product <= mul_product;
        res_valid   <= 1'b1;
`ifdef MUL_ISSUE_TAG_EN
        res_tag     <= op_tag;
`endif
      end else if (retire) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_unit.sv
// tb_mul_issue_unit: scoreboard bench with a behavioural multiplier.
// Define MUL_ISSUE_TAG_EN to also check tag pairing.
module tb_mul_issue_unit;
  import mul_pkg::*;

  localparam int LAT = 17;
  localparam int NV  = 11;

  localparam logic [31:0] VOP [NV] = '{
    32'h5678_1234, 32'h0002_0003, 32'hFFFF_FFFF, 32'h0100_0100,
    32'h0000_1234, 32'h8000_0002, 32'h0010_0020, 32'h1234_0001,
    32'h00FF_00FF, 32'h0003_0005, 32'h0007_0009
  };
  localparam logic [31:0] VP [NV] = '{
    32'h0626_0060, 32'h0000_0006, 32'hFFFE_0001, 32'h0001_0000,
    32'h0000_0000, 32'h0001_0000, 32'h0000_0200, 32'h0000_1234,
    32'h0000_FE01, 32'h0000_000F, 32'h0000_003F
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        mul_start;
  logic [15:0] mul_multiplicand;
  logic [15:0] mul_multiplier;
  logic        mul_done;
  logic [31:0] mul_product;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_product;
  logic        busy;
`ifdef MUL_ISSUE_TAG_EN
  logic [3:0]  in_tag;
  logic [3:0]  res_tag;
`endif

  int n_vec = 0;
  int n_err = 0;
  int starts = 0;
  logic stall = 1'b0;
  logic [31:0] exp_q [$];
  logic [3:0]  tag_q [$];

  mul_issue_unit dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
`ifdef MUL_ISSUE_TAG_EN
    .in_tag           (in_tag),
    .res_tag          (res_tag),
`endif
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_done         (mul_done),
    .mul_product      (mul_product),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_product      (res_product),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input int k);
    operand_pair_t op;
    int n = 0;
    op = VOP[k];
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: in_ready=0 required 1");
    end else begin
      in_valid = 1'b1;
      in_a     = op.a;
      in_b     = op.b;
`ifdef MUL_ISSUE_TAG_EN
      in_tag   = 4'(k + 1);
`endif
      exp_q.push_back(VP[k]);
      tag_q.push_back(4'(k + 1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_res(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // behavioural multiplier: done LAT cycles after start, or later if stalled
  initial begin
    logic [15:0] ca;
    logic [15:0] cb;
    bit ok;
    bit abort;
    mul_done    = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      if (!rst && mul_start) begin
        starts++;
        ca = mul_multiplicand;
        cb = mul_multiplier;
        ok = 1'b1;
        abort = 1'b0;
        for (int i = 1; i < LAT && !abort; i++) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
          else if (mul_start || mul_multiplicand != ca ||
                   mul_multiplier != cb) ok = 1'b0;
        end
        while (stall && !abort) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
          else if (mul_start || mul_multiplicand != ca ||
                   mul_multiplier != cb) ok = 1'b0;
        end
        if (!abort) begin
          check("operands_stable", 32'(ok), 32'd1);
          mul_done    = 1'b1;
          mul_product = 32'(ca) * 32'(cb);
          @(negedge clk);
          mul_done    = 1'b0;
          mul_product = '0;
          check("res_valid_latency", 32'(res_valid), 32'd1);
        end
      end
    end
  end

  // scoreboard monitor: one pop per accepted result
  initial begin
    logic [3:0] t;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %h required none",
                   res_product);
        end else begin
          check("res_product", res_product, exp_q.pop_front());
          t = tag_q.pop_front();
`ifdef MUL_ISSUE_TAG_EN
          check("res_tag", 32'(res_tag), 32'(t));
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    bit stable;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
`ifdef MUL_ISSUE_TAG_EN
    in_tag    = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mcand", 32'(mul_multiplicand), 32'd0);
    check("rst_res_product", res_product, 32'd0);
    rst = 1'b0;

    repeat (10) @(negedge clk);
    check("idle_starts", 32'(starts), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    push(0);
    check("start_n1", 32'(mul_start), 32'd0);
    check("busy_after_push", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("start_n2", 32'(mul_start), 32'd1);
    check("mcand_issue", 32'(mul_multiplicand), 32'h5678);
    check("mplier_issue", 32'(mul_multiplier), 32'h1234);
    @(posedge clk);
    #1;
    check("start_n3", 32'(mul_start), 32'd0);
    wait_res(100);

    for (int k = 1; k <= 4; k++) begin
      push(k);
      if (k == 3) check("hold_ready_3", 32'(in_ready), 32'd1);
    end
    check("hold_full", 32'(in_ready), 32'd0);
    held = res_product;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid || res_product != held) stable = 1'b0;
    end
    check("hold_product", held, 32'h0626_0060);
    check("hold_stable", 32'(stable), 32'd1);
    check("hold_starts", 32'(starts), 32'd1);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain(1000);
    @(posedge clk);
    #1;
    check("drain1_busy", 32'(busy), 32'd0);
    check("drain1_starts", 32'(starts), 32'd5);

    stall = 1'b1;
    for (int k = 5; k <= 9; k++) begin
      push(k);
      if (k == 8) check("bb_ready_4", 32'(in_ready), 32'd1);
    end
    check("bb_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'hDEAD;
    in_b     = 16'hBEEF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("bb_full_hold", 32'(in_ready), 32'd0);
    check("bb_starts", 32'(starts), 32'd6);
    stall = 1'b0;
    drain(2000);
    @(posedge clk);
    #1;
    check("drain2_busy", 32'(busy), 32'd0);

    stall = 1'b1;
    for (int k = 1; k <= 4; k++) push(k);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mcand", 32'(mul_multiplicand), 32'd0);
    check("mid_rst_mplier", 32'(mul_multiplier), 32'd0);
    check("mid_rst_product", res_product, 32'd0);
    exp_q.delete();
    tag_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_starts", 32'(starts), 32'd11);
    push(10);
    drain(200);
    @(posedge clk);
    #1;
    check("final_busy", 32'(busy), 32'd0);
    check("final_starts", 32'(starts), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
